// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the unified memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_IF_BUSY  = 2'd1,
    ARB_MEM_BUSY = 2'd2
  } arb_state_e;

  function automatic int streak_w(input int max_streak);
    return (max_streak < 2) ? 1 : $clog2(max_streak + 1);
  endfunction

  function automatic int timeout_w(input int timeout_cycles);
    return (timeout_cycles < 2) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Down-counter that fires a one-cycle expire when a bus transfer waits too long.
// TIMEOUT_CYCLES of 0 disables it.
module bus_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  input  logic hit,
  output logic expire
);

  localparam int TW = timeout_w(TIMEOUT_CYCLES);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= TW'(TIMEOUT_CYCLES);
    end else if (en && !hit && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  // The last waiting cycle is the one that sees the count at 1.
  assign expire = (TIMEOUT_CYCLES != 0) && en && !hit && (cnt_q == TW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch and the MEM-stage
// load/store path; MEM has priority, bounded by a streak limit while a fetch waits.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int MAX_MEM_STREAK = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  input  logic              if_flush,
  output logic [XLEN-1:0]   if_rdata,
  output logic              if_valid,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_rdata,
  output logic              mem_done,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_wstrb,
  input  logic              bus_ready,
  input  logic [XLEN-1:0]   bus_rdata,
  output logic              bus_err,
  output arb_state_e        dbg_state
);

  // Handshakes: bus_req rises the cycle after a grant and holds addr/we/wdata/wstrb
  // stable until a cycle with bus_req & bus_ready; each requester holds its request
  // until its one-cycle done/valid pulse, and is not re-granted during that pulse.

  localparam int              SW         = streak_w(MAX_MEM_STREAK);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_MEM_STREAK);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] streak_q;
  logic          drop_q;
  logic          if_elig, mem_elig, force_if;
  logic          grant_if, grant_mem;
  logic          busy, xfer_done, expire, finish, drop_now;

  assign if_elig   = if_req & ~if_flush & ~if_valid;
  assign mem_elig  = (mem_rd | mem_wr) & ~mem_done;
  assign force_if  = if_elig & (streak_q == STREAK_MAX);
  assign xfer_done = busy & bus_req & bus_ready;
  assign finish    = xfer_done | expire;
  // A flush landing in the completion cycle itself must also suppress the pulse.
  assign drop_now  = drop_q | ((state_q == ARB_IF_BUSY) & if_flush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (force_if) begin
          grant_if = 1'b1;
          state_d  = ARB_IF_BUSY;
        end else if (mem_elig) begin
          grant_mem = 1'b1;
          state_d   = ARB_MEM_BUSY;
        end else if (if_elig) begin
          grant_if = 1'b1;
          state_d  = ARB_IF_BUSY;
        end
      end
      ARB_IF_BUSY, ARB_MEM_BUSY: begin
        if (finish) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ARB_IDLE);
    stall_if  = if_req & ~if_valid;
    stall_mem = (mem_rd | mem_wr) & ~mem_done;
    dbg_state = state_q;
  end

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (grant_if | grant_mem),
    .en    (busy),
    .hit   (bus_ready),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      mem_done  <= 1'b0;
      mem_rdata <= '0;
    end else begin
      if_valid <= 1'b0;
      mem_done <= 1'b0;
      if (grant_if) begin
        bus_req   <= 1'b1;
        bus_we    <= 1'b0;
        bus_addr  <= if_addr;
        bus_wdata <= '0;
        bus_wstrb <= '1;
      end else if (grant_mem) begin
        // A simultaneous read+write request is serviced as a write.
        bus_req   <= 1'b1;
        bus_we    <= mem_wr;
        bus_addr  <= mem_addr;
        bus_wdata <= mem_wr ? mem_wdata : '0;
        bus_wstrb <= mem_wr ? mem_wstrb : '1;
      end else if (finish) begin
        bus_req <= 1'b0;
      end
      if (finish && (state_q == ARB_IF_BUSY)) begin
        if_valid <= ~drop_now;
        if_rdata <= xfer_done ? bus_rdata : '0;
      end
      if (finish && (state_q == ARB_MEM_BUSY)) begin
        mem_done  <= 1'b1;
        mem_rdata <= xfer_done ? bus_rdata : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
      drop_q   <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      if (grant_if || !if_req) begin
        streak_q <= '0;
      end else if (grant_mem && (streak_q != STREAK_MAX)) begin
        streak_q <= streak_q + SW'(1);
      end
      if (finish && (state_q == ARB_IF_BUSY)) begin
        drop_q <= 1'b0;
      end else if ((state_q == ARB_IF_BUSY) && if_flush) begin
        drop_q <= 1'b1;
      end
      if (expire) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: bus transfers and done/valid
// pulses are checked against queues filled when each stimulus is issued.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk, rst_n;
  logic        if_req, if_flush, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        mem_rd, mem_wr, mem_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        stall_if, stall_mem;
  logic        bus_req, bus_we, bus_ready, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  arb_state_e  dbg_state;

  // {we, addr, wdata, wstrb}
  logic [68:0] exp_bus_q[$];
  // {is_if, check_data, rdata}
  logic [33:0] exp_rsp_q[$];

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int wait_cnt = 0;
  int ready_delay = 0;
  bit stuck = 0;

  mem_port_arbiter #(
    .XLEN(32), .MAX_MEM_STREAK(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory responder ----------------
  assign bus_ready = bus_req && !stuck && (wait_cnt >= ready_delay);
  assign bus_rdata = (bus_addr == 32'h0000_0100) ? 32'hDEAD_BEEF : ~bus_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    wait_cnt <= 0;
    else if (bus_req && !bus_ready) wait_cnt <= wait_cnt + 1;
    else                           wait_cnt <= 0;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // which: 0 = mem_done, 1 = if_valid. Returns at the negedge of the pulse cycle.
  task automatic wait_pulse(input int which, input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if ((which == 0) ? mem_done : if_valid) seen = 1;
    end
    chk(name, seen, 1);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [68:0] mon_bus;
  logic [33:0] mon_rsp;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_req && bus_ready) begin
        hs_cnt++;
        if (exp_bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected: got addr %0h expected no transfer", bus_addr);
        end else begin
          mon_bus = exp_bus_q.pop_front();
          chk("bus_xfer", {bus_we, bus_addr, bus_wdata, bus_wstrb}, mon_bus);
        end
      end
      if (if_valid || mem_done) begin
        if (exp_rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got if_valid=%0b mem_done=%0b expected none", if_valid, mem_done);
        end else begin
          mon_rsp = exp_rsp_q.pop_front();
          chk("rsp_kind", {if_valid, mem_done}, {mon_rsp[33], ~mon_rsp[33]});
          if (mon_rsp[32]) chk("rsp_data", mon_rsp[33] ? if_rdata : mem_rdata, mon_rsp[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int hs0;
  int busy_n;
  bit seen4;

  initial begin
    rst_n = 1'b0;
    if_req = 0; if_addr = '0; if_flush = 0;
    mem_rd = 0; mem_wr = 0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    #12;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_outputs", {bus_we, bus_addr, bus_wstrb, if_valid, mem_done, bus_err}, 0);
    chk("rst_rdata", {if_rdata, mem_rdata}, 0);
    chk("rst_state", dbg_state, ARB_IDLE);
    cyc();
    rst_n = 1'b1;
    cyc();

    // 1: single load, minimum latency
    cyc();
    mem_rd = 1; mem_addr = 32'h100;
    exp_bus_q.push_back({1'b0, 32'h100, 32'h0, 4'hF});
    exp_rsp_q.push_back({1'b0, 1'b1, 32'hDEAD_BEEF});
    @(negedge clk);
    chk("t1_c0_stall", stall_mem, 1);
    chk("t1_c0_bus_req", bus_req, 0);
    cyc(); @(negedge clk);
    chk("t1_c1_bus_req", bus_req, 1);
    chk("t1_c1_addr", bus_addr, 32'h100);
    chk("t1_c1_stall", stall_mem, 1);
    cyc(); @(negedge clk);
    chk("t1_c2_done", mem_done, 1);
    chk("t1_c2_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("t1_c2_stall", stall_mem, 0);
    chk("t1_c2_no_regrant", dbg_state, ARB_IDLE);
    cyc(); mem_rd = 0;
    cyc(); @(negedge clk);
    chk("t1_idle_bus_req", bus_req, 0);

    // 6: read+write together is one write
    cyc();
    hs0 = hs_cnt;
    mem_rd = 1; mem_wr = 1; mem_addr = 32'h300; mem_wdata = 32'h1234_5678; mem_wstrb = 4'h3;
    exp_bus_q.push_back({1'b1, 32'h300, 32'h1234_5678, 4'h3});
    exp_rsp_q.push_back({1'b0, 1'b0, 32'h0});
    wait_pulse(0, "t6_done");
    cyc(); mem_rd = 0; mem_wr = 0;
    repeat (3) cyc();
    chk("t6_single_xfer", hs_cnt - hs0, 1);

    // 2: both held; the done-cycle mask hands the slot to the other side
    cyc();
    exp_bus_q.push_back({1'b1, 32'h1000, 32'h5555_0000, 4'hF});
    exp_bus_q.push_back({1'b0, 32'h2000, 32'h0, 4'hF});
    exp_bus_q.push_back({1'b1, 32'h1004, 32'h5555_0001, 4'hF});
    exp_bus_q.push_back({1'b0, 32'h2004, 32'h0, 4'hF});
    exp_bus_q.push_back({1'b1, 32'h1008, 32'h5555_0002, 4'hF});
    exp_bus_q.push_back({1'b0, 32'h2008, 32'h0, 4'hF});
    exp_rsp_q.push_back({1'b0, 1'b0, 32'h0});
    exp_rsp_q.push_back({1'b1, 1'b1, 32'hFFFF_DFFF});
    exp_rsp_q.push_back({1'b0, 1'b0, 32'h0});
    exp_rsp_q.push_back({1'b1, 1'b1, 32'hFFFF_DFFB});
    exp_rsp_q.push_back({1'b0, 1'b0, 32'h0});
    exp_rsp_q.push_back({1'b1, 1'b1, 32'hFFFF_DFF7});
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          mem_wr = 1; mem_addr = 32'h1000 + 32'(k * 4);
          mem_wdata = 32'h5555_0000 + 32'(k); mem_wstrb = 4'hF;
          wait_pulse(0, "t2_mem_done");
          cyc();
        end
        mem_wr = 0;
      end
      begin
        for (int k = 0; k < 3; k++) begin
          if_req = 1; if_addr = 32'h2000 + 32'(k * 4);
          wait_pulse(1, "t2_if_valid");
          cyc();
        end
        if_req = 0;
      end
    join
    repeat (2) cyc();

    // Streak: fetch pending but flushed while four stores go through, then forced
    if_req = 1; if_addr = 32'h4000; if_flush = 1;
    for (int k = 0; k < 4; k++) begin
      exp_bus_q.push_back({1'b1, 32'h3000 + 32'(k * 4), 32'h6600_0000 + 32'(k), 4'hF});
      exp_rsp_q.push_back({1'b0, 1'b0, 32'h0});
    end
    exp_bus_q.push_back({1'b0, 32'h4000, 32'h0, 4'hF});
    exp_rsp_q.push_back({1'b1, 1'b1, 32'hFFFF_BFFF});
    exp_bus_q.push_back({1'b1, 32'h3010, 32'h6600_0004, 4'hF});
    exp_rsp_q.push_back({1'b0, 1'b0, 32'h0});
    for (int k = 0; k < 4; k++) begin
      mem_wr = 1; mem_addr = 32'h3000 + 32'(k * 4);
      mem_wdata = 32'h6600_0000 + 32'(k); mem_wstrb = 4'hF;
      wait_pulse(0, "st_mem_done");
      cyc(); mem_wr = 0;
      cyc();
    end
    mem_wr = 1; mem_addr = 32'h3010; mem_wdata = 32'h6600_0004;
    if_flush = 0;
    @(negedge clk);
    chk("st_forced_if", dbg_state, ARB_IDLE);
    cyc(); @(negedge clk);
    chk("st_if_owner", dbg_state, ARB_IF_BUSY);
    wait_pulse(1, "st_if_valid");
    cyc(); if_req = 0;
    wait_pulse(0, "st_mem5_done");
    cyc(); mem_wr = 0;
    repeat (2) cyc();

    // 3: fetch flushed while waiting on a slow bus
    ready_delay = 3;
    if_req = 1; if_addr = 32'h200;
    exp_bus_q.push_back({1'b0, 32'h200, 32'h0, 4'hF});
    @(negedge clk);
    chk("t3_stall_if", stall_if, 1);
    cyc(); if_flush = 1; if_req = 0;
    @(negedge clk);
    chk("t3_addr_b1", {bus_req, bus_addr}, {1'b1, 32'h200});
    for (int i = 2; i <= 4; i++) begin
      cyc(); if_flush = 0;
      @(negedge clk);
      chk("t3_addr_hold", {bus_req, bus_addr}, {1'b1, 32'h200});
    end
    cyc(); @(negedge clk);
    chk("t3_no_valid", if_valid, 0);
    chk("t3_idle", dbg_state, ARB_IDLE);
    cyc(); @(negedge clk);
    chk("t3_no_valid_late", if_valid, 0);
    ready_delay = 0;

    // 4: watchdog on a store that never gets bus_ready
    stuck = 1;
    cyc();
    mem_wr = 1; mem_addr = 32'h400; mem_wdata = 32'hCAFE_0000; mem_wstrb = 4'hF;
    exp_rsp_q.push_back({1'b0, 1'b1, 32'h0});
    busy_n = 0; seen4 = 0;
    for (int i = 0; i < 30 && !seen4; i++) begin
      @(negedge clk);
      if (bus_req) busy_n++;
      if (mem_done) seen4 = 1;
    end
    chk("t4_done_seen", seen4, 1);
    chk("t4_busy_cycles", busy_n, 8);
    chk("t4_bus_req_drop", bus_req, 0);
    chk("t4_err_set", bus_err, 1);
    cyc(); mem_wr = 0;
    repeat (3) cyc();
    chk("t4_err_sticky", bus_err, 1);

    // 5: async reset in the middle of a MEM transfer
    mem_rd = 1; mem_addr = 32'h500;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_bus_req", bus_req, 0);
    chk("t5_outputs", {bus_we, bus_addr, bus_wstrb, mem_done, bus_err}, 0);
    chk("t5_state", dbg_state, ARB_IDLE);
    mem_rd = 0;
    repeat (2) cyc();
    rst_n = 1'b1; stuck = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_stale_done", mem_done, 0);
      cyc();
    end
    mem_rd = 1; mem_addr = 32'h600;
    exp_bus_q.push_back({1'b0, 32'h600, 32'h0, 4'hF});
    exp_rsp_q.push_back({1'b0, 1'b1, 32'hFFFF_F9FF});
    wait_pulse(0, "t5_new_done");
    cyc(); mem_rd = 0;
    repeat (3) cyc();

    chk("bus_q_drained", exp_bus_q.size(), 0);
    chk("rsp_q_drained", exp_rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
